// File: rtl/control_sequencer_if.sv
// control_sequencer_if: run/memory handshake, IR feedback and datapath control strobes
// between the hardwired control sequencer (master) and the datapath (slave).
interface control_sequencer_if #(
    parameter int unsigned CNT_W = 16
);
    logic             run;
    logic             mem_ready;
    logic [31:0]      ir;

    logic             PCout;
    logic             Zlowout;
    logic             MDRout;
    logic             MARin;
    logic             Zin;
    logic             PCin;
    logic             MDRin;
    logic             IRin;
    logic             Yin;
    logic             IncPC;
    logic             Read;
    logic             Gra;
    logic             Grb;
    logic             Grc;
    logic             Rin;
    logic             Rout;
    logic [4:0]       alu_op;
    logic             alu_go;
    logic             halted;
    logic             illegal;
    logic [CNT_W-1:0] instr_count;

    // Sequencer side
    modport master (
        input  run, mem_ready, ir,
        output PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin,
               IncPC, Read, Gra, Grb, Grc, Rin, Rout, alu_op, alu_go,
               halted, illegal, instr_count
    );

    // Datapath side
    modport slave (
        output run, mem_ready, ir,
        input  PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin,
               IncPC, Read, Gra, Grb, Grc, Rin, Rout, alu_op, alu_go,
               halted, illegal, instr_count
    );
endinterface

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired Moore control unit. Fetch T0-T2 (T1 waits on mem_ready),
// execute T3-T5 for register-format ALU ops, nop/halt handling, retired-instruction count.
// Optional feature macro: ILLEGAL_TRAP_EN -- when defined, an unsupported opcode in T3
// sets the sticky illegal flag and halts; otherwise it retires as a nop.
// Strobes decode the current state and the live IR (the IR is loaded at the end of T2,
// so T3 decode cannot be precomputed a cycle early); all are forced to 0 while reset is high.
module control_sequencer #(
    parameter int unsigned CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    control_sequencer_if.master  bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T0   = 3'd1,
        S_T1   = 3'd2,
        S_T2   = 3'd3,
        S_T3   = 3'd4,
        S_T4   = 3'd5,
        S_T5   = 3'd6,
        S_HALT = 3'd7
    } state_t;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_SHR  = 5'b00101;
    localparam logic [4:0] OP_SHL  = 5'b00110;
    localparam logic [4:0] OP_AND  = 5'b01001;
    localparam logic [4:0] OP_OR   = 5'b01010;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       opcode;
    logic             op_alu;
    logic             op_nop;
    logic             op_halt;
    logic             retire;

    assign opcode = bus.ir[31:27];

    // Opcode classification
    always_comb begin
        op_alu  = 1'b0;
        op_nop  = 1'b0;
        op_halt = 1'b0;
        case (opcode)
            OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_AND, OP_OR: op_alu = 1'b1;
            OP_NOP:  op_nop  = 1'b1;
            OP_HALT: op_halt = 1'b1;
            default: ;
        endcase
    end

`ifdef ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;
`endif

    // Next-state, retire and counter logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retire  = 1'b0;
`ifdef ILLEGAL_TRAP_EN
        illegal_d = illegal_q;
`endif
        case (state_q)
            S_IDLE: if (bus.run) state_d = S_T0;
            S_T0:   state_d = S_T1;
            S_T1:   if (bus.mem_ready) state_d = S_T2;
            S_T2:   state_d = S_T3;
            S_T3: begin
                if (op_alu) begin
                    state_d = S_T4;
                end else if (op_halt) begin
                    state_d = S_HALT;
                end else if (op_nop) begin
                    retire = 1'b1;
                end else begin
`ifdef ILLEGAL_TRAP_EN
                    illegal_d = 1'b1;
                    state_d   = S_HALT;
`else
                    retire = 1'b1;
`endif
                end
            end
            S_T4:   state_d = S_T5;
            S_T5:   retire = 1'b1;
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
        if (retire) begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = bus.run ? S_T0 : S_IDLE;
        end
    end

    // State and counter registers, synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
`ifdef ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
`ifdef ILLEGAL_TRAP_EN
            illegal_q <= illegal_d;
`endif
        end
    end

    // Moore strobe decode from current state and IR
    always_comb begin
        bus.PCout   = 1'b0;
        bus.Zlowout = 1'b0;
        bus.MDRout  = 1'b0;
        bus.MARin   = 1'b0;
        bus.Zin     = 1'b0;
        bus.PCin    = 1'b0;
        bus.MDRin   = 1'b0;
        bus.IRin    = 1'b0;
        bus.Yin     = 1'b0;
        bus.IncPC   = 1'b0;
        bus.Read    = 1'b0;
        bus.Gra     = 1'b0;
        bus.Grb     = 1'b0;
        bus.Grc     = 1'b0;
        bus.Rin     = 1'b0;
        bus.Rout    = 1'b0;
        bus.alu_op  = 5'b0;
        bus.alu_go  = 1'b0;
        bus.halted  = 1'b0;
        if (!reset) begin
            case (state_q)
                S_T0: begin
                    bus.PCout = 1'b1;
                    bus.MARin = 1'b1;
                    bus.IncPC = 1'b1;
                    bus.Zin   = 1'b1;
                end
                S_T1: begin
                    bus.Zlowout = 1'b1;
                    bus.PCin    = 1'b1;
                    bus.Read    = 1'b1;
                    bus.MDRin   = 1'b1;
                end
                S_T2: begin
                    bus.MDRout = 1'b1;
                    bus.IRin   = 1'b1;
                end
                S_T3: begin
                    if (op_alu) begin
                        bus.Grb  = 1'b1;
                        bus.Rout = 1'b1;
                        bus.Yin  = 1'b1;
                    end
                end
                S_T4: begin
                    bus.Grc    = 1'b1;
                    bus.Rout   = 1'b1;
                    bus.Zin    = 1'b1;
                    bus.alu_go = 1'b1;
                    bus.alu_op = opcode;
                end
                S_T5: begin
                    bus.Zlowout = 1'b1;
                    bus.Gra     = 1'b1;
                    bus.Rin     = 1'b1;
                end
                S_HALT: bus.halted = 1'b1;
                default: ;
            endcase
        end
    end

    // Status outputs, reading 0 while reset is held
    assign bus.instr_count = reset ? '0 : cnt_q;
`ifdef ILLEGAL_TRAP_EN
    assign bus.illegal = reset ? 1'b0 : illegal_q;
`else
    assign bus.illegal = 1'b0;
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed and randomized instruction streams; expected per-cycle
// strobe traces are built from the instruction-level phase rules (fetch, decode, execute).
module tb_control_sequencer;

    localparam int unsigned CNT_W = 16;

`ifdef ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    // Observed vector layout: 17 strobes, alu_op[4:0], halted, illegal
    localparam logic [23:0] B_PCOUT   = 24'(1) << 23;
    localparam logic [23:0] B_ZLOW    = 24'(1) << 22;
    localparam logic [23:0] B_MDROUT  = 24'(1) << 21;
    localparam logic [23:0] B_MARIN   = 24'(1) << 20;
    localparam logic [23:0] B_ZIN     = 24'(1) << 19;
    localparam logic [23:0] B_PCIN    = 24'(1) << 18;
    localparam logic [23:0] B_MDRIN   = 24'(1) << 17;
    localparam logic [23:0] B_IRIN    = 24'(1) << 16;
    localparam logic [23:0] B_YIN     = 24'(1) << 15;
    localparam logic [23:0] B_INCPC   = 24'(1) << 14;
    localparam logic [23:0] B_READ    = 24'(1) << 13;
    localparam logic [23:0] B_GRA     = 24'(1) << 12;
    localparam logic [23:0] B_GRB     = 24'(1) << 11;
    localparam logic [23:0] B_GRC     = 24'(1) << 10;
    localparam logic [23:0] B_RIN     = 24'(1) << 9;
    localparam logic [23:0] B_ROUT    = 24'(1) << 8;
    localparam logic [23:0] B_ALUGO   = 24'(1) << 7;
    localparam logic [23:0] B_HALTED  = 24'(1) << 1;

    localparam logic [23:0] E_T0  = B_PCOUT | B_MARIN | B_INCPC | B_ZIN;
    localparam logic [23:0] E_T1  = B_ZLOW | B_PCIN | B_READ | B_MDRIN;
    localparam logic [23:0] E_T2  = B_MDROUT | B_IRIN;
    localparam logic [23:0] E_T3A = B_GRB | B_ROUT | B_YIN;
    localparam logic [23:0] E_T4  = B_GRC | B_ROUT | B_ZIN | B_ALUGO;
    localparam logic [23:0] E_T5  = B_ZLOW | B_GRA | B_RIN;

    logic clk = 1'b0;
    logic reset;

    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned cnt_m    = 0;
    logic        ill_m    = 1'b0;

    always #5 clk = ~clk;

    control_sequencer_if #(.CNT_W(CNT_W)) bus ();

    control_sequencer #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    // 0 = ALU, 1 = nop, 2 = halt, 3 = unsupported
    function automatic int op_kind(input logic [4:0] op);
        case (op)
            5'd3, 5'd4, 5'd5, 5'd6, 5'd9, 5'd10: return 0;
            5'd26: return 1;
            5'd27: return 2;
            default: return 3;
        endcase
    endfunction

    // Check the current cycle, then drive inputs for the coming edge
    task automatic step(input logic [23:0] exp, input string tag, input logic r,
                        input logic mr, input logic rs, input logic [31:0] irv);
        logic [23:0] obs;
        logic [23:0] exp_full;
        logic [CNT_W-1:0] exp_cnt;
        @(negedge clk);
        #1;
        obs = {bus.PCout, bus.Zlowout, bus.MDRout, bus.MARin, bus.Zin, bus.PCin,
               bus.MDRin, bus.IRin, bus.Yin, bus.IncPC, bus.Read, bus.Gra, bus.Grb,
               bus.Grc, bus.Rin, bus.Rout, bus.alu_go, bus.alu_op, bus.halted, bus.illegal};
        exp_full = reset ? 24'h0 : (exp | 24'(ill_m));
        exp_cnt  = reset ? '0 : CNT_W'(cnt_m);
        n_checks++;
        assert (obs === exp_full) else begin
            n_fail++;
            $error("FAIL %s strobes: got %06h expected %06h", tag, obs, exp_full);
        end
        n_checks++;
        assert (bus.instr_count === exp_cnt) else begin
            n_fail++;
            $error("FAIL %s instr_count: got %0d expected %0d", tag, bus.instr_count, exp_cnt);
        end
        bus.run       = r;
        bus.mem_ready = mr;
        reset         = rs;
        bus.ir        = irv;
    endtask

    // One instruction starting in T0; stopped=1 when it ends in HALT
    task automatic do_instr(input logic [31:0] irv, input int stall, input logic run_next,
                            output bit stopped);
        logic [4:0] op;
        int k;
        op = irv[31:27];
        k  = op_kind(op);
        stopped = 1'b0;
        step(E_T0, "T0", rb(), rb(), 1'b0, irv);
        for (int i = 0; i <= stall; i++)
            step(E_T1, "T1", rb(), (i == stall), 1'b0, irv);
        step(E_T2, "T2", rb(), rb(), 1'b0, irv);
        if (k == 0) begin
            step(E_T3A, "T3_alu", rb(), rb(), 1'b0, irv);
            step(E_T4 | (24'(op) << 2), "T4", rb(), rb(), 1'b0, irv);
            step(E_T5, "T5", run_next, rb(), 1'b0, irv);
            cnt_m++;
        end else if (k == 1 || (k == 3 && !TRAP)) begin
            step(24'h0, "T3_nop", run_next, rb(), 1'b0, irv);
            cnt_m++;
        end else begin
            step(24'h0, "T3_stop", rb(), rb(), 1'b0, irv);
            if (k == 3) ill_m = 1'b1;
            stopped = 1'b1;
        end
    endtask

    task automatic halt_hold(input int n);
        for (int i = 0; i < n; i++)
            step(B_HALTED, "HALT", rb(), rb(), 1'b0, $urandom);
    endtask

    // Assert reset from a known state, hold it ncyc cycles, release with run=1
    task automatic reset_from(input logic [23:0] exp_now, input string tag, input int ncyc);
        step(exp_now, tag, 1'b1, rb(), 1'b1, $urandom);
        cnt_m = 0;
        ill_m = 1'b0;
        for (int i = 0; i < ncyc; i++)
            step(24'h0, "RST", 1'b1, rb(), (i < ncyc - 1), $urandom);
    endtask

    logic [4:0] alu_ops [6] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd9, 5'd10};

    initial begin
        bit          stopped;
        logic [4:0]  op;
        logic [31:0] irv;
        int          sel;
        logic        rn;

        reset         = 1'b1;
        bus.run       = 1'b1;
        bus.mem_ready = 1'b0;
        bus.ir        = 32'h0;

        // Reset two cycles with run held high, then release into T0
        step(24'h0, "RST0", 1'b1, 1'b0, 1'b1, 32'h0);
        step(24'h0, "RST1", 1'b1, 1'b1, 1'b0, 32'h0);

        // AND, no stall, straight into the next fetch
        do_instr(32'h4A920000, 0, 1'b1, stopped);
        // ADD with 3-cycle memory stall
        do_instr(32'h18000000, 3, 1'b1, stopped);
        // nop, then drop run at retire and idle
        do_instr(32'hD0000000, 0, 1'b0, stopped);
        step(24'h0, "IDLE", 1'b0, 1'b1, 1'b0, 32'h0);
        step(24'h0, "IDLE", 1'b1, 1'b0, 1'b0, 32'h0);
        // halt, hold 10 cycles with run high
        do_instr(32'hD8000000, 1, 1'b1, stopped);
        for (int i = 0; i < 10; i++)
            step(B_HALTED, "HALT10", 1'b1, rb(), 1'b0, 32'hD8000000);
        reset_from(B_HALTED, "HALT_RST", 1);

        // Unsupported opcode
        do_instr(32'h00000000, 0, 1'b1, stopped);
        if (stopped) begin
            halt_hold(3);
            reset_from(B_HALTED, "ILL_RST", 1);
        end

        // Reset asserted while in T4
        do_instr(32'hD0000000, 0, 1'b1, stopped);
        step(E_T0, "T0", 1'b1, 1'b1, 1'b0, 32'h20000000);
        step(E_T1, "T1", 1'b1, 1'b1, 1'b0, 32'h20000000);
        step(E_T2, "T2", 1'b1, 1'b1, 1'b0, 32'h20000000);
        step(E_T3A, "T3_alu", 1'b1, 1'b1, 1'b0, 32'h20000000);
        step(E_T4 | (24'(5'd4) << 2), "T4_pre_rst", 1'b1, 1'b1, 1'b1, 32'h20000000);
        cnt_m = 0;
        ill_m = 1'b0;
        step(24'h0, "T4_RST", 1'b0, 1'b1, 1'b0, 32'h0);
        step(24'h0, "IDLE_after", 1'b1, 1'b1, 1'b0, 32'h0);
        do_instr(32'h4A920000, 0, 1'b1, stopped);

        // Randomized instruction stream
        for (int n = 0; n < 60; n++) begin
            sel = int'($urandom_range(0, 19));
            if (sel < 12) begin
                op = alu_ops[sel % 6];
            end else if (sel < 16) begin
                op = 5'd26;
            end else if (sel < 17) begin
                op = 5'd27;
            end else begin
                op = 5'($urandom);
                while (op_kind(op) != 3) op = 5'($urandom);
            end
            irv = {op, 27'($urandom)};
            rn  = ($urandom_range(0, 3) != 0);
            do_instr(irv, int'($urandom_range(0, 3)), rn, stopped);
            if (stopped) begin
                halt_hold(int'($urandom_range(1, 4)));
                reset_from(B_HALTED, "RND_RST", int'($urandom_range(1, 2)));
            end else if (!rn) begin
                sel = int'($urandom_range(1, 3));
                for (int i = 0; i < sel; i++)
                    step(24'h0, "IDLE_rnd", (i == sel - 1), rb(), 1'b0, $urandom);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Hardwired control unit that sits directly upstream of the datapath and generates, cycle by cycle, the register-transfer control strobes the datapath consumes. It runs the three-step instruction fetch (T0–T2) and the three-step execute (T3–T5) for register-format ALU instructions, and waits on a memory-ready handshake during the fetch read. It decodes the instruction register contents fed back from the datapath, and counts retired instructions.

## Interface
Parameters:
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- run  in  1  enables fetch of the next instruction.
- mem_ready  in  1  memory read data valid on Mdatain.
- ir  in  32  datapath IR contents: opcode ir[31:27], ra ir[26:23], rb ir[22:19], rc ir[18:15].
- PCout, Zlowout, MDRout  out  1 each  datapath bus-drive strobes.
- MARin, Zin, PCin, MDRin, IRin, Yin  out  1 each  datapath register-load strobes.
- IncPC, Read  out  1 each  ALU increment-PC select; memory read request.
- Gra, Grb, Grc  out  1 each  select the ra/rb/rc field as the register-file address.
- Rin, Rout  out  1 each  register-file load / drive for the selected register.
- alu_op  out  5  opcode presented to the ALU; valid only while alu_go=1, otherwise 0.
- alu_go  out  1  ALU operation strobe.
- halted  out  1  sequencer is in the HALT state.
- illegal  out  1  sticky unsupported-opcode flag.
- instr_count  out  CNT_W  retired-instruction count.

## Operation
- Moore FSM states: IDLE, T0, T1, T2, T3, T4, T5, HALT. Every strobe is a pure function of the current state and ir. A strobe not listed for a state is 0.
- IDLE: all strobes 0. Goes to T0 when run=1.
- T0: PCout, MARin, IncPC, Zin. Goes to T1.
- T1: Zlowout, PCin, Read, MDRin. All four are held for every cycle spent in T1. Goes to T2 on the edge where mem_ready=1; otherwise stays in T1.
- T2: MDRout, IRin. Goes to T3.
- T3: decode ir[31:27].
  - ALU opcodes 00011 add, 00100 sub, 00101 shr, 00110 shl, 01001 and, 01010 or: assert Grb, Rout, Yin; go to T4.
  - 11010 nop: no strobes; the instruction retires.
  - 11011 halt: no strobes; go to HALT.
  - Any other opcode: see Configuration.
- T4: Grc, Rout, Zin, alu_go, alu_op = ir[31:27]. Goes to T5.
- T5: Zlowout, Gra, Rin. The instruction retires.
- Retire: instr_count increments by 1 and wraps modulo 2^CNT_W. The next state is T0 if run=1, IDLE otherwise.
- HALT: halted=1, all strobes 0. Leaves only on reset; run is ignored.
- run is sampled only in IDLE and at retire. Dropping run mid-instruction does not abort it.

## Timing
- Reset: on the next edge, state=IDLE, instr_count=0, illegal=0. All outputs read 0 during and after reset.
- Reset asserted in any state, including mid-T1 wait or T4, overrides every other transition.
- Strobes change only after a clock edge. Each is stable for the whole cycle, so the datapath captures on the edge that ends the state.
- Latency with mem_ready already high: ALU instruction 6 cycles (T0–T5); nop 4 cycles (T0–T3).
- Each cycle mem_ready stays low in T1 adds one cycle.
- mem_ready is ignored outside T1.
- Back-to-back instructions with run=1: the cycle after T5 (or after a nop's T3) is T0, with no idle bubble.

## Configuration
- ILLEGAL_TRAP_EN defined: an unsupported opcode in T3 sets illegal=1 (sticky until reset) and goes to HALT. instr_count is not incremented.
- ILLEGAL_TRAP_EN undefined: an unsupported opcode executes as a nop and retires. illegal is tied to 0.

## Test plan
- Reset: assert reset for 2 cycles with run=1 -> all strobes 0, halted=0, illegal=0, instr_count=0.
- AND instruction: run=1, mem_ready=1, ir=0x4A920000 ->
  - T0 PCout/MARin/IncPC/Zin; T1 Zlowout/PCin/Read/MDRin; T2 MDRout/IRin.
  - T3 Grb/Rout/Yin; T4 Grc/Rout/Zin/alu_go with alu_op=5'b01001; T5 Zlowout/Gra/Rin.
  - instr_count=1; next cycle is T0.
- Memory stall: hold mem_ready=0 for 3 cycles in T1 -> Read/MDRin high for 4 consecutive cycles; IRin asserted in the cycle after mem_ready rises.
- nop and halt:
  - ir=0xD0000000 -> returns to T0 after T3, instr_count increments, no register strobes in T3.
  - Then ir=0xD8000000 -> halted=1, all strobes 0, state unchanged for 10 cycles with run=1.
- Illegal opcode ir=0x00000000:
  - With ILLEGAL_TRAP_EN: illegal=1, halted=1, count unchanged.
  - Without ILLEGAL_TRAP_EN: retires as nop, illegal=0.
- Reset during T4 -> next cycle IDLE with alu_go=0, instr_count=0; a new run=1 restarts cleanly at T0.
